wb_stage: RTL and testbench

Registered writeback stage for the pipelined RV32I core, between the memory stage and the register file. It selects the writeback result by `res_src` (ALU, memory, PC+4, LUI, AUIPC) and waits for variable-latency load data through a valid handshake. It aligns and extends sub-word loads, checks load alignment and timeout, and issues a one-cycle register-file write.

---
 rtl/wb_stage.sv | 187 ++++++++++++++++++
 tb/tb_wb_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Registered RV32I writeback stage: result select, variable-latency load wait, alignment/timeout checks.
// Sub-word load extraction and misalignment checking are enabled by defining WB_LOAD_EXT_EN.
module wb_stage #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_res_src,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_imm_lui,
  input  logic [XLEN-1:0] in_imm_auipc,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_err,
  output logic            busy
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            mis_q, mis_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;

  logic            accept;
  logic            is_mem;
  logic            timeout;
  logic            mis_new;
  logic [XLEN-1:0] sel_res;
  logic [XLEN-1:0] load_data;

  assign accept  = in_valid && in_ready;
  assign is_mem  = (in_res_src == 3'd1);
  assign timeout = (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    sel_res = in_alu_res;
    case (in_res_src)
      3'd2:    sel_res = in_pc_plus4;
      3'd3:    sel_res = in_imm_lui;
      3'd4:    sel_res = in_imm_auipc;
      default: sel_res = in_alu_res;
    endcase
  end

`ifdef WB_LOAD_EXT_EN
  logic [XLEN-1:0] shifted;
  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = shifted;
    case (f3_q)
      3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Undefined load encodings behave as LW, so they need a word-aligned address.
  always_comb begin
    mis_new = 1'b0;
    case (in_funct3)
      3'b001, 3'b101: mis_new = in_alu_res[0];
      3'b000, 3'b100: mis_new = 1'b0;
      default:        mis_new = (in_alu_res[1:0] != 2'b00);
    endcase
  end
`else
  logic unused_ext;
  assign unused_ext = ^{f3_q, off_q};
  assign load_data  = mem_rdata;
  assign mis_new    = 1'b0;
`endif

  // State register and per-instruction load context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      mis_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      mis_q   <= mis_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept && is_mem) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid || timeout) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write address/data only change when a write is actually issued.
  always_comb begin
    rd_d    = rd_q;
    rw_d    = rw_q;
    f3_d    = f3_q;
    off_d   = off_q;
    mis_d   = mis_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (accept && !is_mem && in_reg_write && in_rd != 5'd0) begin
        we_d    = 1'b1;
        waddr_d = in_rd;
        wdata_d = sel_res;
      end else if (accept && is_mem) begin
        rd_d  = in_rd;
        rw_d  = in_reg_write;
        f3_d  = in_funct3;
        off_d = in_alu_res[1:0];
        mis_d = mis_new;
      end
    end else if (mem_rvalid) begin
      if (mis_q) begin
        err_d = 1'b1;
      end else if (rw_q && rd_q != 5'd0) begin
        we_d    = 1'b1;
        waddr_d = rd_q;
        wdata_d = load_data;
      end
    end else if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q == S_WAIT);
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: ALU/load vector tables, timeout, late data and mid-wait reset sequences.
module tb_wb_stage;

  localparam int XLEN        = 32;
  localparam int MEM_TIMEOUT = 16;
  localparam int W           = 2 + 5 + XLEN;
`ifdef WB_LOAD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_res_src;
  logic [XLEN-1:0] in_alu_res;
  logic [XLEN-1:0] in_pc_plus4;
  logic [XLEN-1:0] in_imm_lui;
  logic [XLEN-1:0] in_imm_auipc;
  logic [2:0]      in_funct3;
  logic [4:0]      in_rd;
  logic            in_reg_write;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            load_err;
  logic            busy;

  wb_stage #(.XLEN(XLEN), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_res_src(in_res_src), .in_alu_res(in_alu_res),
    .in_pc_plus4(in_pc_plus4), .in_imm_lui(in_imm_lui), .in_imm_auipc(in_imm_auipc),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .load_err(load_err), .busy(busy)
  );

  // Clock / reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  int checks   = 0;
  int failures = 0;

  // Entry: {load_err, rf_we, rf_waddr, rf_wdata}; error entries compare only the top two bits.
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor on the falling edge.
  always @(negedge clk) begin
    if (rst_n && (rf_we || load_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb", {62'd0, load_err, rf_we}, 64'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (e[W-1])
          check("sb_err", {62'd0, load_err, rf_we}, {62'd0, e[W-1:W-2]});
        else
          check("sb_write", {25'd0, load_err, rf_we, rf_waddr, rf_wdata}, {25'd0, e});
      end
    end
  end

  typedef struct {
    logic [2:0]  src;
    logic [4:0]  rd;
    logic        rw;
    logic        exp_we;
    logic [31:0] exp_data;
  } alu_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] exp_ext;
    logic        mis_ext;
  } ld_vec_t;

  alu_vec_t avec[8];
  ld_vec_t  lvec[13];

  task automatic drive_idle();
    in_valid     = 1'b0;
    in_res_src   = 3'd0;
    in_alu_res   = '0;
    in_pc_plus4  = '0;
    in_imm_lui   = '0;
    in_imm_auipc = '0;
    in_funct3    = 3'd0;
    in_rd        = 5'd0;
    in_reg_write = 1'b0;
  endtask

  task automatic start_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd);
    in_valid     = 1'b1;
    in_res_src   = 3'd1;
    in_alu_res   = 32'h0000_1000 | {30'd0, off};
    in_funct3    = f3;
    in_rd        = rd;
    in_reg_write = 1'b1;
    step();
    in_valid     = 1'b0;
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata,
                          input logic [4:0] rd, input int dly, input logic exp_we,
                          input logic exp_err, input logic [31:0] exp_data);
    if (exp_we) exp_q.push_back({1'b0, 1'b1, rd, exp_data});
    else if (exp_err) exp_q.push_back({1'b1, 1'b0, 5'd0, 32'd0});
    start_load(f3, off, rd);
    for (int k = 1; k < dly; k++) begin
      check("wait_quiet", {60'd0, rf_we, load_err, busy, in_ready}, 64'b0010);
      step();
    end
    check("wait_busy", {62'd0, busy, in_ready}, 64'b10);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    check("load_we", {63'd0, rf_we}, {63'd0, exp_we});
    check("load_err", {63'd0, load_err}, {63'd0, exp_err});
    check("load_idle", {62'd0, busy, in_ready}, 64'b01);
  endtask

  initial begin
    avec[0] = '{3'd0, 5'd1,  1'b1, 1'b1, 32'hA000_0000};
    avec[1] = '{3'd2, 5'd2,  1'b1, 1'b1, 32'hB000_0001};
    avec[2] = '{3'd3, 5'd3,  1'b1, 1'b1, 32'hC000_0002};
    avec[3] = '{3'd4, 5'd4,  1'b1, 1'b1, 32'hD000_0003};
    avec[4] = '{3'd7, 5'd5,  1'b1, 1'b1, 32'hA000_0004};
    avec[5] = '{3'd5, 5'd0,  1'b1, 1'b0, 32'h0};
    avec[6] = '{3'd6, 5'd20, 1'b0, 1'b0, 32'h0};
    avec[7] = '{3'd2, 5'd31, 1'b1, 1'b1, 32'hB000_0007};

    lvec[0]  = '{3'b000, 2'd3, 32'h80FF_00FF, 5'd6,  32'hFFFF_FF80, 1'b0};
    lvec[1]  = '{3'b100, 2'd3, 32'h80FF_00FF, 5'd7,  32'h0000_0080, 1'b0};
    lvec[2]  = '{3'b101, 2'd2, 32'h80FF_00FF, 5'd8,  32'h0000_80FF, 1'b0};
    lvec[3]  = '{3'b001, 2'd2, 32'h80FF_0000, 5'd9,  32'hFFFF_80FF, 1'b0};
    lvec[4]  = '{3'b001, 2'd0, 32'h0000_7FFE, 5'd10, 32'h0000_7FFE, 1'b0};
    lvec[5]  = '{3'b010, 2'd0, 32'hDEAD_BEEF, 5'd11, 32'hDEAD_BEEF, 1'b0};
    lvec[6]  = '{3'b010, 2'd1, 32'hCAFE_F00D, 5'd12, 32'h0,         1'b1};
    lvec[7]  = '{3'b001, 2'd1, 32'h1234_5678, 5'd13, 32'h0,         1'b1};
    lvec[8]  = '{3'b011, 2'd0, 32'hA5A5_A5A5, 5'd14, 32'hA5A5_A5A5, 1'b0};
    lvec[9]  = '{3'b000, 2'd1, 32'h0000_7F00, 5'd15, 32'h0000_007F, 1'b0};
    lvec[10] = '{3'b100, 2'd0, 32'h0000_00FE, 5'd16, 32'h0000_00FE, 1'b0};
    lvec[11] = '{3'b000, 2'd0, 32'h0000_00FE, 5'd0,  32'h0,         1'b0};
    lvec[12] = '{3'b110, 2'd2, 32'h0BAD_F00D, 5'd17, 32'h0,         1'b1};

    // Reset state.
    rst_n      = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    drive_idle();
    repeat (3) step();
    check("reset_ctrl", {60'd0, in_ready, busy, rf_we, load_err}, 64'b1000);
    check("reset_waddr", {59'd0, rf_waddr}, 64'd0);
    check("reset_wdata", {32'd0, rf_wdata}, 64'd0);
    rst_n = 1'b1;
    step();

    // Single ALU op.
    in_valid = 1'b1; in_res_src = 3'd0; in_alu_res = 32'h1234_5678;
    in_rd = 5'd5; in_reg_write = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 5'd5, 32'h1234_5678});
    step();
    drive_idle();
    check("alu_we", {63'd0, rf_we}, 64'd1);
    check("alu_waddr", {59'd0, rf_waddr}, 64'd5);
    check("alu_wdata", {32'd0, rf_wdata}, 64'h1234_5678);
    check("alu_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("alu_pulse", {63'd0, rf_we}, 64'd0);

    // Back-to-back non-load table.
    for (int i = 0; i < 8; i++) begin
      in_valid     = 1'b1;
      in_res_src   = avec[i].src;
      in_alu_res   = 32'hA000_0000 | i;
      in_pc_plus4  = 32'hB000_0000 | i;
      in_imm_lui   = 32'hC000_0000 | i;
      in_imm_auipc = 32'hD000_0000 | i;
      in_rd        = avec[i].rd;
      in_reg_write = avec[i].rw;
      if (avec[i].exp_we) exp_q.push_back({1'b0, 1'b1, avec[i].rd, avec[i].exp_data});
      step();
      check("vec_we", {63'd0, rf_we}, {63'd0, avec[i].exp_we});
      check("vec_ready", {63'd0, in_ready}, 64'd1);
    end
    drive_idle();
    step();
    check("vec_drain", {63'd0, rf_we}, 64'd0);

    // Load table.
    for (int i = 0; i < 13; i++) begin
      logic [31:0] ed;
      logic        mis;
      ed  = EXT ? lvec[i].exp_ext : lvec[i].rdata;
      mis = EXT ? lvec[i].mis_ext : 1'b0;
      run_load(lvec[i].f3, lvec[i].off, lvec[i].rdata, lvec[i].rd,
               (i == 0) ? 3 : $urandom_range(1, 4),
               !mis && (lvec[i].rd != 5'd0), mis, ed);
      step();
    end

    // Timeout: error MEM_TIMEOUT cycles after entering WAIT.
    exp_q.push_back({1'b1, 1'b0, 5'd0, 32'd0});
    start_load(3'b010, 2'd0, 5'd18);
    for (int k = 1; k < MEM_TIMEOUT; k++) begin
      step();
      check("to_wait", {60'd0, rf_we, load_err, busy, in_ready}, 64'b0010);
    end
    step();
    check("to_err", {60'd0, rf_we, load_err, busy, in_ready}, 64'b0101);
    step();
    check("to_pulse", {63'd0, load_err}, 64'd0);
    // Late data in IDLE is ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    step();
    step();
    mem_rvalid = 1'b0;
    check("late_data", {61'd0, rf_we, load_err, busy}, 64'd0);

    // Data arriving on the timeout cycle wins.
    exp_q.push_back({1'b0, 1'b1, 5'd19, 32'h7777_0000});
    start_load(3'b010, 2'd0, 5'd19);
    for (int k = 1; k < MEM_TIMEOUT; k++) step();
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_0000;
    step();
    mem_rvalid = 1'b0;
    check("to_race", {62'd0, rf_we, load_err}, 64'b10);
    check("to_race_data", {32'd0, rf_wdata}, 64'h7777_0000);
    step();

    // Reset while waiting.
    start_load(3'b010, 2'd0, 5'd21);
    step();
    rst_n = 1'b0;
    #1;
    check("rst_wait", {60'd0, busy, in_ready, rf_we, load_err}, 64'b0100);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    rst_n = 1'b1;
    step();
    check("rst_after", {60'd0, busy, in_ready, rf_we, load_err}, 64'b0100);
    mem_rvalid = 1'b0;
    step();
    check("rst_quiet", {62'd0, rf_we, load_err}, 64'd0);

    repeat (2) step();
    check("queue_drain", exp_q.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
